prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_word_asm.sv | 26 ++
 rtl/prog_loader.sv | 108 ++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// States are plain localparams so legacy tools and lint agree on encoding.
package prog_loader_pkg;

  localparam int DEF_AW         = 7;
  localparam int DEF_IW         = 18;
  localparam int BYTES_PER_WORD = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEN   = 3'd1;
  localparam state_t ST_B0    = 3'd2;
  localparam state_t ST_B1    = 3'd3;
  localparam state_t ST_B2    = 3'd4;
  localparam state_t ST_WRITE = 3'd5;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-lane register assembling one instruction word from host bytes.
// Latency: lane updated on the cycle after cap; no backpressure of its own.
module word_asm #(
  parameter int IW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic [1:0]    lane,
  input  logic [7:0]    byte_in,
  output logic [IW-1:0] wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata <= '0;
    end else if (cap) begin
      case (lane)
        2'd0:    wdata[7:0]     <= byte_in;
        2'd1:    wdata[15:8]    <= byte_in;
        default: wdata[IW-1:16] <= byte_in[IW-17:0];
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Host byte-stream loader into instruction memory: LEN byte, then 3 bytes/word.
// Latency: write one cycle after a word's third byte; in_ready drops in IDLE and WRITE.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [IW-1:0] wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  state_t      state;
  logic [AW:0] cnt;
  logic [AW:0] total;
  logic [AW:0] cnt_nxt;
  logic        xfer;
  logic        b2_bad;
  logic        cap;
  logic [1:0]  lane;

  assign in_ready = (state == ST_LEN) || (state == ST_B0) ||
                    (state == ST_B1)  || (state == ST_B2);
  assign cpu_hold = (state != ST_IDLE);
  assign we       = (state == ST_WRITE);
  assign cnt_nxt  = cnt + 1'b1;
  assign done     = we && (cnt_nxt == total);
  assign xfer     = in_valid && in_ready;
  // Only two payload bits live in the top byte; anything above is a framing error.
  assign b2_bad   = |in_data[7:IW-16];

  always_comb begin
    cap  = 1'b0;
    lane = 2'd2;
    case (state)
      ST_B0: begin cap = xfer; lane = 2'd0; end
      ST_B1: begin cap = xfer; lane = 2'd1; end
      ST_B2: begin cap = xfer && !b2_bad; lane = 2'd2; end
      default: ;
    endcase
  end

  word_asm #(.IW(IW)) u_word_asm (
    .clk     (clk),
    .rst     (rst),
    .cap     (cap),
    .lane    (lane),
    .byte_in (in_data),
    .wdata   (wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      total <= '0;
      waddr <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LEN;
            err   <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            total <= (in_data == 8'd0) ? FULL_COUNT : (AW+1)'(in_data);
            state <= ST_B0;
          end
        end
        ST_B0: if (xfer) state <= ST_B1;
        ST_B1: if (xfer) state <= ST_B2;
        ST_B2: begin
          if (xfer) begin
            if (b2_bad) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              waddr <= cnt[AW-1:0];
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          cnt   <= cnt_nxt;
          state <= done ? ST_IDLE : ST_B0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard popped by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        we;
  logic [6:0]  waddr;
  logic [17:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  typedef struct {
    logic [6:0]  a;
    logic [17:0] d;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   nwr  = 0;

  prog_loader #(.AW(7), .IW(18)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the oldest scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (done) check("done_without_we", {31'd0, we}, 32'd1);
      if (we) begin
        nwr++;
        check("in_ready_in_write", {31'd0, in_ready}, 32'd0);
        if (sb.size() == 0) begin
          check("we_spurious", {31'd0, we}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("waddr", {25'd0, waddr}, {25'd0, e.a});
          check("wdata", {14'd0, wdata}, {14'd0, e.d});
          check("done",  {31'd0, done},  {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t = 0;
    while (1) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) break;
      end
      t++;
      if (t > 200) begin
        check("byte_timeout", t, 0);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [6:0] a, input logic [17:0] d, input bit last, input bit rnd);
    exp_t e;
    send_byte(d[7:0], rnd);
    send_byte(d[15:8], rnd);
    e.a = a; e.d = d; e.last = last;
    sb.push_back(e);
    send_byte({6'd0, d[17:16]}, rnd);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, sb.size(), 0);
    @(negedge clk);
    check({tag, "_cpu_hold_after"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  logic [17:0] pat [3];
  int          w0;

  initial begin
    pat[0] = 18'h31234; pat[1] = 18'h15678; pat[2] = 18'h2ABCD;

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",       {31'd0, we},       32'd0);
    check("rst_waddr",    {25'd0, waddr},    32'd0);
    check("rst_wdata",    {14'd0, wdata},    32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two words back to back
    pulse_start();
    check("len_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("len_in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'd2, 1'b0);
    send_word(7'd0, 18'h31234, 1'b0, 1'b0);
    send_word(7'd1, 18'h15678, 1'b1, 1'b0);
    drain("two_word");

    // Format error in the third byte
    pulse_start();
    send_byte(8'd1, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h05, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("err_set",        {31'd0, err},      32'd1);
    check("err_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
    check("err_in_ready",   {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("err_sticky",     {31'd0, err},      32'd1);
    pulse_start();
    check("err_cleared",    {31'd0, err},      32'd0);
    send_byte(8'd1, 1'b0);
    send_word(7'd0, 18'h00001, 1'b1, 1'b0);
    drain("after_err");

    // Full 128-word load, payload = address
    w0 = nwr;
    pulse_start();
    send_byte(8'd0, 1'b0);
    for (int i = 0; i < 128; i++)
      send_word(7'(i), 18'(i), (i == 127), 1'b0);
    drain("full");
    repeat (10) @(negedge clk);
    check("full_write_count", nwr - w0, 128);

    // Three words with in_valid toggling
    pulse_start();
    send_byte(8'd3, 1'b1);
    for (int i = 0; i < 3; i++)
      send_word(7'(i), pat[i], (i == 2), 1'b1);
    drain("random_valid");

    // start during B0 must not disturb the load
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_word(7'd0, 18'h3FFFF, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b0_start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(7'd1, 18'h20406, 1'b1, 1'b0);
    drain("start_in_b0");

    // Reset while in B1 of the second word
    pulse_start();
    send_byte(8'd3, 1'b0);
    send_word(7'd0, 18'h2AAAA, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_we",       {31'd0, we},       32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_waddr",    {25'd0, waddr},    32'd0);
    check("mid_rst_wdata",    {14'd0, wdata},    32'd0);
    check("mid_rst_done",     {31'd0, done},     32'd0);
    check("mid_rst_sb_empty", sb.size(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = nwr;
    repeat (10) @(negedge clk);
    check("mid_rst_no_write", nwr - w0, 0);
    pulse_start();
    send_byte(8'd1, 1'b0);
    send_word(7'd0, 18'h1BEEF, 1'b1, 1'b0);
    drain("reload");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
